// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption key schedule: expands a loaded key into 11 buffered
// round keys, then serves them round 10 down to 0 over a valid/ack handshake.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b)
               : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15;
  logic [7:0] x30, x60, x120, x240;
  logic [7:0] x252, inv;

  // Inverse as x^254 over GF(2^8), then the affine map
  always_comb begin
    x2   = gmul(a_i, a_i);
    x3   = gmul(x2, a_i);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    s_o  = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

module aes_dec_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] key_in,
  input  logic         key_load,
  input  logic         blk_start,
  input  logic         rk_ack,
  output logic         busy,
  output logic         keys_ready,
  output logic         rk_valid,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    SERVE
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] rko_q, rko_d;
  logic         exp_we;

  logic [0:127] kbuf_q [0:10];

  logic [0:127] cur;
  logic [0:31]  w0, w1, w2, w3;
  logic [0:31]  rot, sub, t;
  logic [0:31]  w0n, w1n, w2n, w3n;
  logic [0:127] nxt;
  logic [7:0]   rcon;

  always_comb begin
    unique case (rc_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign cur = kbuf_q[rc_q];
  assign w0  = cur[0:31];
  assign w1  = cur[32:63];
  assign w2  = cur[64:95];
  assign w3  = cur[96:127];
  assign rot = {w3[8:31], w3[0:7]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (rot[8*i +: 8]),
      .s_o (sub[8*i +: 8])
    );
  end

  assign t   = sub ^ {rcon, 24'h000000};
  assign w0n = w0 ^ t;
  assign w1n = w1 ^ w0n;
  assign w2n = w2 ^ w1n;
  assign w3n = w3 ^ w2n;
  assign nxt = {w0n, w1n, w2n, w3n};

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    rnd_d   = rnd_q;
    rko_d   = rko_q;
    exp_we  = 1'b0;
    if (key_load) begin
      state_d = EXPAND;
      rc_d    = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: ;
        EXPAND: begin
          exp_we = 1'b1;
          if (rc_q == 4'd9) state_d = READY;
          else              rc_d    = rc_q + 4'd1;
        end
        READY: begin
          if (blk_start) begin
            state_d = SERVE;
            rnd_d   = 4'd10;
            rko_d   = kbuf_q[10];
          end
        end
        SERVE: begin
          if (rk_ack) begin
            if (rnd_q == 4'd0) begin
              state_d = READY;
            end else begin
              rnd_d = rnd_q - 4'd1;
              rko_d = kbuf_q[rnd_q - 4'd1];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= 4'd0;
      rnd_q   <= 4'd0;
      rko_q   <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rnd_q   <= rnd_d;
      rko_q   <= rko_d;
    end
  end

  // Buffer contents are never reset; validity is tracked by the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (key_load)
        kbuf_q[0] <= key_in;
      else if (exp_we)
        kbuf_q[rc_q + 4'd1] <= nxt;
    end
  end

  assign busy       = (state_q == EXPAND);
  assign keys_ready = (state_q == READY) || (state_q == SERVE);
  assign rk_valid   = (state_q == SERVE);
  assign rk_out     = rko_q;
  assign rk_round   = rnd_q;
  assign rk_last    = rk_valid && (rnd_q == 4'd0);

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Directed bench for aes_dec_key_sched using FIPS-197 key expansion
// vectors and the all-counting key 000102..0f.

module tb_aes_dec_key_sched;

  logic         clk;
  logic         rst;
  logic [0:127] key_in;
  logic         key_load;
  logic         blk_start;
  logic         rk_ack;
  logic         busy;
  logic         keys_ready;
  logic         rk_valid;
  logic [0:127] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;

  int checks = 0;
  int errors = 0;

  logic [127:0] k1r [0:10];
  logic [127:0] k2;
  logic [127:0] k2r10;

  aes_dec_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .blk_start  (blk_start),
    .rk_ack     (rk_ack),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_valid   (rk_valid),
    .rk_out     (rk_out),
    .rk_round   (rk_round),
    .rk_last    (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  128'(busy),       128'd0);
    chk({tag, "_rdy"},   128'(keys_ready), 128'd0);
    chk({tag, "_vld"},   128'(rk_valid),   128'd0);
    chk({tag, "_rnd"},   128'(rk_round),   128'd0);
    chk({tag, "_last"},  128'(rk_last),    128'd0);
    chk({tag, "_out"},   rk_out,           128'd0);
  endtask

  initial begin
    k1r[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k1r[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    k1r[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    k1r[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    k1r[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    k1r[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    k1r[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    k1r[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    k1r[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    k1r[9]  = 128'hac7766f319fadc2128d12941575c006e;
    k1r[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    k2      = 128'h000102030405060708090a0b0c0d0e0f;
    k2r10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst       = 1'b1;
    key_in    = '0;
    key_load  = 1'b0;
    blk_start = 1'b0;
    rk_ack    = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset("reset");

    // Nominal expansion, with a stray blk_start mid-way
    key_in   = k1r[0];
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("exp_busy", 128'(busy), 128'd1);
      chk("exp_rdy",  128'(keys_ready), 128'd0);
      chk("exp_vld",  128'(rk_valid), 128'd0);
      blk_start = (i == 3);
      step();
    end
    blk_start = 1'b0;
    chk("n11_busy", 128'(busy), 128'd0);
    chk("n11_rdy",  128'(keys_ready), 128'd1);
    chk("n11_vld",  128'(rk_valid), 128'd0);

    // Serve with a stall, then ack held high
    blk_start = 1'b1;
    step();
    blk_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_vld", 128'(rk_valid), 128'd1);
      chk("stall_rnd", 128'(rk_round), 128'd10);
      chk("stall_out", rk_out, k1r[10]);
      step();
    end
    rk_ack = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      chk("full_vld",  128'(rk_valid), 128'd1);
      chk("full_rnd",  128'(rk_round), 128'(r));
      chk("full_out",  rk_out, k1r[r]);
      chk("full_last", 128'(rk_last), 128'(r == 0));
      step();
    end
    rk_ack = 1'b0;
    chk("post_vld",  128'(rk_valid), 128'd0);
    chk("post_last", 128'(rk_last), 128'd0);
    chk("post_rdy",  128'(keys_ready), 128'd1);
    chk("post_hold", rk_out, k1r[0]);

    // Ack while idle-ready is ignored
    rk_ack = 1'b1;
    step();
    rk_ack = 1'b0;
    chk("ign_ack_vld", 128'(rk_valid), 128'd0);
    chk("ign_ack_rdy", 128'(keys_ready), 128'd1);
    chk("ign_ack_out", rk_out, k1r[0]);

    // Two blocks under random back-pressure, no re-expansion
    for (int b = 0; b < 2; b++) begin
      int r;
      int guard;
      int a;
      blk_start = 1'b1;
      step();
      blk_start = 1'b0;
      r = 10;
      guard = 0;
      while (r >= 0 && guard < 200) begin
        chk("bp_vld",  128'(rk_valid), 128'd1);
        chk("bp_rnd",  128'(rk_round), 128'(r));
        chk("bp_out",  rk_out, k1r[r]);
        chk("bp_last", 128'(rk_last), 128'(r == 0));
        chk("bp_busy", 128'(busy), 128'd0);
        a = int'($urandom_range(0, 1));
        rk_ack = a[0];
        step();
        if (a != 0) r--;
        guard++;
      end
      rk_ack = 1'b0;
      chk("bp_done", 128'(r), 128'hffffffffffffffffffffffffffffffff);
      chk("bp_end_vld", 128'(rk_valid), 128'd0);
    end

    // Abort a serve at round 6 with a new key
    blk_start = 1'b1;
    step();
    blk_start = 1'b0;
    rk_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rk_ack = 1'b0;
    chk("ab_rnd", 128'(rk_round), 128'd6);
    chk("ab_out", rk_out, k1r[6]);
    key_in   = k2;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("ab_vld",  128'(rk_valid), 128'd0);
    chk("ab_busy", 128'(busy), 128'd1);
    chk("ab_rdy",  128'(keys_ready), 128'd0);
    chk("ab_hold", rk_out, k1r[6]);
    for (int i = 0; i < 10; i++) step();
    chk("ab_n11_rdy",  128'(keys_ready), 128'd1);
    chk("ab_n11_busy", 128'(busy), 128'd0);
    blk_start = 1'b1;
    step();
    blk_start = 1'b0;
    chk("ab_r10_rnd", 128'(rk_round), 128'd10);
    chk("ab_r10_out", rk_out, k2r10);
    rk_ack = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rk_ack = 1'b0;
    chk("ab_r0_out",  rk_out, k2);
    chk("ab_r0_last", 128'(rk_last), 128'd1);
    rk_ack = 1'b1;
    step();
    rk_ack = 1'b0;
    chk("ab_r0_done", 128'(rk_valid), 128'd0);

    // key_load wins over blk_start in the same cycle
    key_in    = k1r[0];
    key_load  = 1'b1;
    blk_start = 1'b1;
    step();
    key_load  = 1'b0;
    blk_start = 1'b0;
    chk("pri_busy", 128'(busy), 128'd1);
    chk("pri_vld",  128'(rk_valid), 128'd0);
    for (int i = 0; i < 10; i++) step();
    chk("pri_rdy", 128'(keys_ready), 128'd1);
    blk_start = 1'b1;
    step();
    blk_start = 1'b0;
    chk("pri_r10", rk_out, k1r[10]);

    // Reset while rc=4 during expansion
    key_in   = k2;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst_pre_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst_mid");
    blk_start = 1'b1;
    step();
    blk_start = 1'b0;
    chk("rst_blk_vld", 128'(rk_valid), 128'd0);
    chk("rst_blk_rdy", 128'(keys_ready), 128'd0);
    step();
    chk_reset("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
